control_timing_unit: RTL and testbench

CONTROL_TIMING_UNIT -- requirements
Module: control_timing_unit

---
 rtl/control_timing_unit_pkg.sv | 24 ++
 rtl/control_timing_unit_sc_decoder.sv | 11 +
 rtl/control_timing_unit.sv | 127 ++++++++++++
 tb/tb_control_timing_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/control_timing_unit_pkg.sv
// Shared constants for the control timing unit.
//   BUS_*  : bus_select source encodings driven onto the common bus
//   OP_*   : IR[14:12] opcode values, used as indices into the D decode
package control_timing_unit_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam int OP_AND = 0;
  localparam int OP_ADD = 1;
  localparam int OP_LDA = 2;
  localparam int OP_STA = 3;
  localparam int OP_BUN = 4;
  localparam int OP_BSA = 5;
  localparam int OP_ISZ = 6;
  localparam int OP_REG = 7;  // register-reference (I=0) / I/O (I=1)

endpackage

// File: rtl/control_timing_unit_sc_decoder.sv
// sc_decoder: 4-to-16 one-hot timing decoder.
//   sc : sequence counter value
//   t  : one-hot timing signals T0..T15
module sc_decoder (
  input  logic [3:0]  sc,
  output logic [15:0] t
);

  assign t = 16'd1 << sc;

endmodule

// File: rtl/control_timing_unit.sv
// control_timing_unit: hardwired control sequencer for a basic accumulator
// computer. Holds the sequence counter SC and the I flip-flop; every
// control output is combinational from SC, the opcode decode, I, B and
// status inputs.
//   clk, rst                : clock, async active-high reset
//   IR                      : instruction register (I, opcode, B)
//   IRQ/IEN/FGI/FGO/E       : interrupt and I/O status flags
//   AC_MSB/AC_zero/DR_zero  : datapath status
//   register/flag controls  : one strobe per micro-operation
//   ALU_*                   : one-hot ALU function select
//   RAM_r, RAM_w            : memory strobes
//   bus_select              : common-bus source
module control_timing_unit
  import control_timing_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        IRQ, IEN, FGI, FGO, E,
  input  logic        AC_MSB, AC_zero, DR_zero,
  output logic        load_AR, clr_AR, inc_AR, load_PC, clr_PC, inc_PC,
  output logic        load_DR, inc_DR, load_AC, clr_AC, inc_AC,
  output logic        load_IR, load_TR, load_OUTR,
  output logic        set_IRQ, clr_IRQ, set_IEN, clr_IEN, load_E, clr_E,
  output logic        comp_E, clr_S, clr_FGI, clr_FGO,
  output logic        ALU_and, ALU_add, ALU_comp, ALU_cir, ALU_cil,
  output logic        ALU_trans_dr, ALU_trans_inpr,
  output logic        RAM_r, RAM_w,
  output logic [2:0]  bus_select
);

  logic [3:0]  sc;
  logic [15:0] t;
  logic [7:0]  d;
  logic [11:0] b;
  logic        i_ff, clr_sc, t_idle;

  sc_decoder u_sc_dec (.sc(sc), .t(t));

  assign d = 8'd1 << IR[14:12];
  assign b = IR[11:0];
  // No step is defined past T6; if SC ever runs there, stay silent until it wraps.
  assign t_idle = |t[15:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc   <= 4'd0;
      i_ff <= 1'b0;
    end else begin
      sc <= clr_sc ? 4'd0 : sc + 4'd1;
      if (t[2] && !IRQ) i_ff <= IR[15];
    end
  end

  always_comb begin
    {load_AR, clr_AR, inc_AR, load_PC, clr_PC, inc_PC, load_DR, inc_DR} = '0;
    {load_AC, clr_AC, inc_AC, load_IR, load_TR, load_OUTR} = '0;
    {set_IRQ, clr_IRQ, set_IEN, clr_IEN, load_E, clr_E, comp_E, clr_S} = '0;
    {clr_FGI, clr_FGO, RAM_w} = '0;
    {ALU_and, ALU_add, ALU_comp, ALU_cir, ALU_cil, ALU_trans_dr, ALU_trans_inpr} = '0;
    bus_select = BUS_NONE;
    clr_sc     = 1'b0;
    // Gating on rst keeps outputs quiet even though SC=0 decodes as T0.
    if (!rst && !t_idle) begin
      set_IRQ = !(t[0] | t[1] | t[2]) & IEN & (FGI | FGO);
      if (!IRQ) begin
        if (t[0]) begin bus_select = BUS_PC;  load_AR = 1'b1; end
        if (t[1]) begin bus_select = BUS_MEM; load_IR = 1'b1; inc_PC = 1'b1; end
        if (t[2]) begin bus_select = BUS_IR;  load_AR = 1'b1; end
      end else begin
        if (t[0]) begin clr_AR = 1'b1; bus_select = BUS_PC; load_TR = 1'b1; end
        if (t[1]) begin bus_select = BUS_TR; RAM_w = 1'b1; clr_PC = 1'b1; end
        if (t[2]) begin inc_PC = 1'b1; clr_IEN = 1'b1; clr_IRQ = 1'b1; clr_sc = 1'b1; end
      end
      if (t[3]) begin
        if (!d[OP_REG]) begin
          if (i_ff) begin bus_select = BUS_MEM; load_AR = 1'b1; end
        end else if (!i_ff) begin
          clr_sc   = 1'b1;
          clr_AC   = b[11];
          clr_E    = b[10];
          ALU_comp = b[9];
          comp_E   = b[8];
          ALU_cir  = b[7];
          ALU_cil  = b[6];
          load_AC  = b[9] | b[7] | b[6];
          load_E   = b[7] | b[6];
          inc_AC   = b[5];
          inc_PC   = (b[4] & !AC_MSB) | (b[3] & AC_MSB) | (b[2] & AC_zero) | (b[1] & !E);
          clr_S    = b[0];
        end else begin
          clr_sc         = 1'b1;
          ALU_trans_inpr = b[11];
          load_AC        = b[11];
          clr_FGI        = b[11];
          if (b[10]) bus_select = BUS_AC;
          load_OUTR      = b[10];
          clr_FGO        = b[10];
          inc_PC         = (b[9] & FGI) | (b[8] & FGO);
          set_IEN        = b[7];
          clr_IEN        = b[6];
        end
      end
      if (t[4]) begin
        if (d[OP_AND] | d[OP_ADD] | d[OP_LDA] | d[OP_ISZ]) begin
          bus_select = BUS_MEM; load_DR = 1'b1;
        end
        if (d[OP_STA]) begin bus_select = BUS_AC; RAM_w = 1'b1; clr_sc = 1'b1; end
        if (d[OP_BUN]) begin bus_select = BUS_AR; load_PC = 1'b1; clr_sc = 1'b1; end
        if (d[OP_BSA]) begin bus_select = BUS_PC; RAM_w = 1'b1; inc_AR = 1'b1; end
      end
      if (t[5]) begin
        if (d[OP_AND]) begin ALU_and = 1'b1; load_AC = 1'b1; clr_sc = 1'b1; end
        if (d[OP_ADD]) begin ALU_add = 1'b1; load_AC = 1'b1; load_E = 1'b1; clr_sc = 1'b1; end
        if (d[OP_LDA]) begin ALU_trans_dr = 1'b1; load_AC = 1'b1; clr_sc = 1'b1; end
        if (d[OP_BSA]) begin bus_select = BUS_AR; load_PC = 1'b1; clr_sc = 1'b1; end
        if (d[OP_ISZ]) inc_DR = 1'b1;
      end
      if (t[6] && d[OP_ISZ]) begin
        bus_select = BUS_DR; RAM_w = 1'b1; inc_PC = DR_zero; clr_sc = 1'b1;
      end
    end
  end

  assign RAM_r = (bus_select == BUS_MEM);

endmodule

// File: tb/tb_control_timing_unit.sv
// Directed bench for control_timing_unit. Expected output vectors are
// pushed to a scoreboard queue as stimulus is applied and popped when the
// outputs are sampled just after the falling edge.
module tb_control_timing_unit;

  logic        clk = 1'b0, rst;
  logic [15:0] IR;
  logic        IRQ, IEN, FGI, FGO, E, AC_MSB, AC_zero, DR_zero;
  logic        load_AR, clr_AR, inc_AR, load_PC, clr_PC, inc_PC;
  logic        load_DR, inc_DR, load_AC, clr_AC, inc_AC, load_IR, load_TR, load_OUTR;
  logic        set_IRQ, clr_IRQ, set_IEN, clr_IEN, load_E, clr_E, comp_E, clr_S;
  logic        clr_FGI, clr_FGO;
  logic        ALU_and, ALU_add, ALU_comp, ALU_cir, ALU_cil, ALU_trans_dr, ALU_trans_inpr;
  logic        RAM_r, RAM_w;
  logic [2:0]  bus_select;

  int n_chk = 0, n_fail = 0;
  logic [35:0] exp_q[$];
  string       tag_q[$];

  localparam logic [35:0] LD_AR = 36'd1 << 0,  CL_AR = 36'd1 << 1,  IN_AR = 36'd1 << 2;
  localparam logic [35:0] LD_PC = 36'd1 << 3,  CL_PC = 36'd1 << 4,  IN_PC = 36'd1 << 5;
  localparam logic [35:0] LD_DR = 36'd1 << 6,  IN_DR = 36'd1 << 7,  LD_AC = 36'd1 << 8;
  localparam logic [35:0] CL_AC = 36'd1 << 9,  LD_IR = 36'd1 << 11, LD_TR = 36'd1 << 12;
  localparam logic [35:0] LD_OUTR = 36'd1 << 13, S_IRQ = 36'd1 << 14, C_IRQ = 36'd1 << 15;
  localparam logic [35:0] C_IEN = 36'd1 << 17, LD_E = 36'd1 << 18;
  localparam logic [35:0] C_FGI = 36'd1 << 22, C_FGO = 36'd1 << 23;
  localparam logic [35:0] A_AND = 36'd1 << 24, A_ADD = 36'd1 << 25, A_INPR = 36'd1 << 30;
  localparam logic [35:0] R_R = 36'd1 << 31, R_W = 36'd1 << 32;

  function automatic logic [35:0] bus(input logic [2:0] s);
    return {s, 33'd0};
  endfunction

  wire [35:0] obs = {bus_select, RAM_w, RAM_r, ALU_trans_inpr, ALU_trans_dr, ALU_cil,
                     ALU_cir, ALU_comp, ALU_add, ALU_and, clr_FGO, clr_FGI, clr_S, comp_E,
                     clr_E, load_E, clr_IEN, set_IEN, clr_IRQ, set_IRQ, load_OUTR, load_TR,
                     load_IR, inc_AC, clr_AC, load_AC, inc_DR, load_DR, inc_PC, clr_PC,
                     load_PC, inc_AR, clr_AR, load_AR};

  control_timing_unit dut (
    .clk(clk), .rst(rst), .IR(IR), .IRQ(IRQ), .IEN(IEN), .FGI(FGI), .FGO(FGO), .E(E),
    .AC_MSB(AC_MSB), .AC_zero(AC_zero), .DR_zero(DR_zero),
    .load_AR(load_AR), .clr_AR(clr_AR), .inc_AR(inc_AR), .load_PC(load_PC),
    .clr_PC(clr_PC), .inc_PC(inc_PC), .load_DR(load_DR), .inc_DR(inc_DR),
    .load_AC(load_AC), .clr_AC(clr_AC), .inc_AC(inc_AC), .load_IR(load_IR),
    .load_TR(load_TR), .load_OUTR(load_OUTR), .set_IRQ(set_IRQ), .clr_IRQ(clr_IRQ),
    .set_IEN(set_IEN), .clr_IEN(clr_IEN), .load_E(load_E), .clr_E(clr_E),
    .comp_E(comp_E), .clr_S(clr_S), .clr_FGI(clr_FGI), .clr_FGO(clr_FGO),
    .ALU_and(ALU_and), .ALU_add(ALU_add), .ALU_comp(ALU_comp), .ALU_cir(ALU_cir),
    .ALU_cil(ALU_cil), .ALU_trans_dr(ALU_trans_dr), .ALU_trans_inpr(ALU_trans_inpr),
    .RAM_r(RAM_r), .RAM_w(RAM_w), .bus_select(bus_select)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Push expectation, let outputs settle, pop and compare.
  task automatic expect_now(input string tag, input logic [35:0] want);
    exp_q.push_back(want);
    tag_q.push_back(tag);
    #1;
    chk(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic cyc(input string tag, input logic [35:0] want);
    expect_now(tag, want);
    @(negedge clk);
  endtask

  task automatic fetch(input string p);
    cyc({p, "_t0"}, bus(3'd2) | LD_AR);
    cyc({p, "_t1"}, bus(3'd7) | R_R | LD_IR | IN_PC);
    cyc({p, "_t2"}, bus(3'd5) | LD_AR);
  endtask

  initial begin
    rst = 1'b1; IR = 16'h0000; IRQ = 0; IEN = 0; FGI = 0; FGO = 0; E = 0;
    AC_MSB = 0; AC_zero = 0; DR_zero = 0;
    repeat (2) @(negedge clk);
    IR = 16'h7800;
    expect_now("rst_quiet", 36'd0);
    rst = 1'b0;

    // CLA
    fetch("cla");
    cyc("cla_t3", CL_AC);
    cyc("cla_next_t0", bus(3'd2) | LD_AR);
    @(negedge clk); @(negedge clk);
    cyc("cla_drain_t3", CL_AC);

    // SPA with AC positive then negative
    IR = 16'h7010; AC_MSB = 0;
    fetch("spa0");
    cyc("spa0_t3", IN_PC);
    AC_MSB = 1;
    fetch("spa1");
    cyc("spa1_t3", 36'd0);
    AC_MSB = 0;

    // ISZ direct with DR reaching zero
    IR = 16'h6040; DR_zero = 1;
    fetch("isz");
    cyc("isz_t3", 36'd0);
    cyc("isz_t4", bus(3'd7) | R_R | LD_DR);
    cyc("isz_t5", IN_DR);
    cyc("isz_t6", bus(3'd3) | R_W | IN_PC);
    DR_zero = 0;

    // BSA
    IR = 16'h5040;
    fetch("bsa");
    cyc("bsa_t3", 36'd0);
    cyc("bsa_t4", bus(3'd2) | R_W | IN_AR);
    cyc("bsa_t5", bus(3'd1) | LD_PC);

    // Indirect AND: effective address fetched at T3
    IR = 16'h8123;
    fetch("andi");
    cyc("andi_t3", bus(3'd7) | R_R | LD_AR);
    cyc("andi_t4", bus(3'd7) | R_R | LD_DR);
    cyc("andi_t5", A_AND | LD_AC);

    // I/O: INP then OUT
    IR = 16'hF800;
    fetch("inp");
    cyc("inp_t3", A_INPR | LD_AC | C_FGI);
    IR = 16'hF400;
    fetch("out");
    cyc("out_t3", bus(3'd4) | LD_OUTR | C_FGO);

    // Interrupt request then interrupt cycle
    IR = 16'h7800; IEN = 1; FGI = 1;
    fetch("irq");
    cyc("irq_t3_set", CL_AC | S_IRQ);
    IRQ = 1;
    cyc("int_t0", CL_AR | bus(3'd2) | LD_TR);
    cyc("int_t1", bus(3'd6) | R_W | CL_PC);
    cyc("int_t2", IN_PC | C_IEN | C_IRQ);
    IRQ = 0; IEN = 0; FGI = 0;
    cyc("int_after_t0", bus(3'd2) | LD_AR);
    @(negedge clk); @(negedge clk);
    cyc("int_drain_t3", CL_AC);

    // ADD with reset landing in the middle of T5
    IR = 16'h1040;
    fetch("add");
    cyc("add_t3", 36'd0);
    cyc("add_t4", bus(3'd7) | R_R | LD_DR);
    expect_now("add_t5", A_ADD | LD_AC | LD_E);
    #2 rst = 1'b1;
    expect_now("rst_mid_t5", 36'd0);
    @(negedge clk);
    expect_now("rst_held", 36'd0);
    rst = 1'b0;
    cyc("post_rst_t0", bus(3'd2) | LD_AR);
    cyc("post_rst_t1", bus(3'd7) | R_R | LD_IR | IN_PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
